// File: rtl/iq_sample_capture_if.sv
// Output stream bundle of the IQ sample capture block: head-of-FIFO I/Q words
// with a valid/ready handshake toward the downstream DSP.
interface iq_sample_capture_if #(
    parameter int DATA_W = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;

    // Capture block side: presents samples, observes downstream readiness.
    modport master (
        output out_valid,
        output out_i,
        output out_q,
        input  out_ready
    );

    // Downstream DSP side: consumes samples, drives readiness.
    modport slave (
        input  out_valid,
        input  out_i,
        input  out_q,
        output out_ready
    );
endinterface

// File: rtl/iq_sample_capture.sv
// IQ sample capture: consumer end of the ADC sample-toggle interface.
// A toggle on sample_event (asynchronous to clk) marks a new I/Q pair. The
// toggle is synchronized, each flip latches the I/Q words (optionally
// converting offset-binary to two's complement) into a small FIFO drained
// through a valid/ready stream. Sticky overflow, a source-stall watchdog and
// a wrapping sample counter are reported alongside.
module iq_sample_capture #(
    parameter int DATA_W         = 10,
    parameter int FIFO_DEPTH     = 4,    // power of 2, at least 2
    parameter int OFFSET_BINARY  = 1,
    parameter int TIMEOUT_CYCLES = 400,
    parameter int COUNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             i_in,
    input  logic [DATA_W-1:0]             q_in,
    input  logic                          sample_event,
    iq_sample_capture_if.master           out_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          stall,
    input  logic                          clr_flags,
    output logic [COUNT_W-1:0]            sample_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LVL_W-1:0]   DEPTH_VAL   = LVL_W'(FIFO_DEPTH);
    localparam logic [STALL_W-1:0] TIMEOUT_VAL = STALL_W'(TIMEOUT_CYCLES);

    // Offset-binary to two's complement is a flip of the sign bit only.
    function automatic logic [DATA_W-1:0] to_stored(input logic [DATA_W-1:0] word);
        if (OFFSET_BINARY != 0) begin
            return {~word[DATA_W-1], word[DATA_W-2:0]};
        end else begin
            return word;
        end
    endfunction

    // Toggle synchronizer; deliberately not reset so the chain keeps tracking
    // the source and no phantom edge appears when reset releases.
    logic sync1_r;
    logic sync2_r;
    logic sync3_r;

    logic detect_s;
    logic full_s;
    logic empty_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [DATA_W-1:0] mem_i_r [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_q_r [FIFO_DEPTH];

    logic               overflow_r;
    logic [COUNT_W-1:0] count_r;
    logic [STALL_W-1:0] idle_r;

    // Three-stage synchronizer of the asynchronous sample toggle.
    always_ff @(posedge clk) begin
        sync1_r <= sample_event;
        sync2_r <= sync1_r;
        sync3_r <= sync2_r;
    end

    // Edge detect and FIFO push/pop/drop decisions for this cycle.
    always_comb begin
        detect_s = 1'b0;
        full_s   = 1'b0;
        empty_s  = 1'b0;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        drop_s   = 1'b0;
        if (reset) begin
            detect_s = 1'b0;
        end else begin
            detect_s = sync2_r ^ sync3_r;
        end
        full_s  = (level_r == DEPTH_VAL);
        empty_s = (level_r == {LVL_W{1'b0}});
        pop_s   = ~empty_s & out_bus.out_ready;
        // A full FIFO still accepts a sample if its head leaves this cycle.
        push_s  = detect_s & (~full_s | pop_s);
        drop_s  = detect_s & full_s & ~pop_s;
    end

    // FIFO storage; contents need no reset since out_valid gates them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_i_r[wr_ptr_r] <= to_stored(i_in);
            mem_q_r[wr_ptr_r] <= to_stored(q_in);
        end
    end

    // FIFO pointers and occupancy level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1'b1);
                2'b01:   level_r <= level_r - LVL_W'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_flags) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Count of samples accepted into the FIFO, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (push_s) begin
            count_r <= count_r + COUNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Source-stall watchdog: cycles since the last detected toggle, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_r <= {STALL_W{1'b0}};
        end else if (detect_s) begin
            idle_r <= {STALL_W{1'b0}};
        end else if (idle_r != TIMEOUT_VAL) begin
            idle_r <= idle_r + STALL_W'(1'b1);
        end else begin
            idle_r <= idle_r;
        end
    end

    // Outputs come straight from registered state; the head entry is shown
    // without an extra stage so a sample is visible right after its push.
    assign out_bus.out_valid = (level_r != {LVL_W{1'b0}});
    assign out_bus.out_i     = mem_i_r[rd_ptr_r];
    assign out_bus.out_q     = mem_q_r[rd_ptr_r];
    assign fifo_level        = level_r;
    assign overflow          = overflow_r;
    assign stall             = (idle_r == TIMEOUT_VAL);
    assign sample_count      = count_r;

endmodule

// File: tb/tb_iq_sample_capture.sv
// Directed bench for iq_sample_capture: instance A uses defaults, instance B
// uses COUNT_W=4 and pass-through data for the wrap and bit-exact checks.
`timescale 1ns/1ps
module tb_iq_sample_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [9:0] i_a, q_a, i_b, q_b;
    logic       ev_a, ev_b, clr_a, clr_b;
    logic [2:0] lvl_a, lvl_b;
    logic       ovf_a, ovf_b, stall_a, stall_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt;

    iq_sample_capture_if #(.DATA_W(10)) bus_a ();
    iq_sample_capture_if #(.DATA_W(10)) bus_b ();

    iq_sample_capture dut_a (
        .clk(clk), .reset(reset), .i_in(i_a), .q_in(q_a), .sample_event(ev_a),
        .out_bus(bus_a), .fifo_level(lvl_a), .overflow(ovf_a), .stall(stall_a),
        .clr_flags(clr_a), .sample_count(cnt_a)
    );

    iq_sample_capture #(.COUNT_W(4), .OFFSET_BINARY(0)) dut_b (
        .clk(clk), .reset(reset), .i_in(i_b), .q_in(q_b), .sample_event(ev_b),
        .out_bus(bus_b), .fifo_level(lvl_b), .overflow(ovf_b), .stall(stall_b),
        .clr_flags(clr_b), .sample_count(cnt_b)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present I/Q one cycle ahead, then flip the toggle.
    task automatic toggle_a(input logic [9:0] i, input logic [9:0] q);
        i_a = i;
        q_a = q;
        tick();
        ev_a = ~ev_a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ev_a = 1'b0; ev_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        i_a = 10'h000; q_a = 10'h000; i_b = 10'h000; q_b = 10'h000;
        bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        tick();
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus_a.out_valid); end
        total++; if (lvl_a !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h want=0", ovf_a); end
        total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", stall_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt_a); end
        total++; if (cnt_b !== 4'd0) begin bad++; $display("FAIL reset_count_b got=%0d want=0", cnt_b); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_basic();
        bus_a.out_ready = 1'b1;
        toggle_a(10'h3FF, 10'h000);
        tick();  // s1 captures the toggle
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early1 got=%0h want=0", bus_a.out_valid); end
        tick();  // detect cycle
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early2 got=%0h want=0", bus_a.out_valid); end
        tick();  // push edge
        exp_cnt = exp_cnt + 16'd1;
        total++; if (bus_a.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h want=1", bus_a.out_valid); end
        total++; if (bus_a.out_i !== 10'h1FF) begin bad++; $display("FAIL basic_i got=%0h want=1ff", bus_a.out_i); end
        total++; if (bus_a.out_q !== 10'h200) begin bad++; $display("FAIL basic_q got=%0h want=200", bus_a.out_q); end
        total++; if (cnt_a !== exp_cnt) begin bad++; $display("FAIL basic_count got=%0d want=%0d", cnt_a, exp_cnt); end
        tick();
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0h want=0", bus_a.out_valid); end
        total++; if (lvl_a !== 3'd0) begin bad++; $display("FAIL basic_level got=%0d want=0", lvl_a); end
    endtask

    task automatic test_overflow();
        logic [9:0] vi [6] = '{10'h001, 10'h2AA, 10'h155, 10'h3C0, 10'h07F, 10'h300};
        logic [9:0] vq [6] = '{10'h200, 10'h0F0, 10'h3FF, 10'h100, 10'h180, 10'h011};
        logic [9:0] ei [4] = '{10'h201, 10'h0AA, 10'h355, 10'h1C0};
        logic [9:0] eq [4] = '{10'h000, 10'h2F0, 10'h1FF, 10'h300};
        bus_a.out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            toggle_a(vi[n], vq[n]);
            repeat (4) tick();
            if (n == 3) begin
                total++; if (lvl_a !== 3'd4) begin bad++; $display("FAIL ovf_level_full got=%0d want=4", lvl_a); end
                total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_not_yet got=%0h want=0", ovf_a); end
            end
            if (n == 4) begin
                total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h want=1", ovf_a); end
            end
            repeat (195) tick();
        end
        exp_cnt = exp_cnt + 16'd4;
        total++; if (lvl_a !== 3'd4) begin bad++; $display("FAIL ovf_level_after got=%0d want=4", lvl_a); end
        total++; if (cnt_a !== exp_cnt) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", cnt_a, exp_cnt); end
        for (int n = 0; n < 4; n++) begin
            total++; if (bus_a.out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid%0d got=%0h want=1", n, bus_a.out_valid); end
            total++; if (bus_a.out_i !== ei[n]) begin bad++; $display("FAIL drain_i%0d got=%0h want=%0h", n, bus_a.out_i, ei[n]); end
            total++; if (bus_a.out_q !== eq[n]) begin bad++; $display("FAIL drain_q%0d got=%0h want=%0h", n, bus_a.out_q, eq[n]); end
            bus_a.out_ready = 1'b1;
            tick();
            bus_a.out_ready = 1'b0;
        end
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0h want=0", bus_a.out_valid); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h want=1", ovf_a); end
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0h want=0", ovf_a); end
    endtask

    task automatic test_full_pop();
        logic [9:0] di [4] = '{10'h241, 10'h242, 10'h243, 10'h260};
        logic [9:0] dq [4] = '{10'h0F0, 10'h0F0, 10'h0F0, 10'h1A0};
        bus_a.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            toggle_a(10'h040 + 10'(n), 10'h2F0);
            repeat (5) tick();
        end
        exp_cnt = exp_cnt + 16'd4;
        total++; if (lvl_a !== 3'd4) begin bad++; $display("FAIL fp_fill got=%0d want=4", lvl_a); end
        // Drop coinciding with a clear: overflow must end up set.
        toggle_a(10'h050, 10'h050);
        tick(); tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL fp_clr_collide got=%0h want=1", ovf_a); end
        total++; if (cnt_a !== exp_cnt) begin bad++; $display("FAIL fp_drop_count got=%0d want=%0d", cnt_a, exp_cnt); end
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL fp_clear got=%0h want=0", ovf_a); end
        // Push and pop in the same cycle on a full FIFO.
        toggle_a(10'h060, 10'h3A0);
        tick(); tick();
        total++; if (bus_a.out_i !== 10'h240) begin bad++; $display("FAIL fp_head got=%0h want=240", bus_a.out_i); end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        total++; if (lvl_a !== 3'd4) begin bad++; $display("FAIL fp_level got=%0d want=4", lvl_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL fp_no_ovf got=%0h want=0", ovf_a); end
        total++; if (cnt_a !== exp_cnt) begin bad++; $display("FAIL fp_count got=%0d want=%0d", cnt_a, exp_cnt); end
        for (int n = 0; n < 4; n++) begin
            total++; if (bus_a.out_i !== di[n]) begin bad++; $display("FAIL fp_drain_i%0d got=%0h want=%0h", n, bus_a.out_i, di[n]); end
            total++; if (bus_a.out_q !== dq[n]) begin bad++; $display("FAIL fp_drain_q%0d got=%0h want=%0h", n, bus_a.out_q, dq[n]); end
            bus_a.out_ready = 1'b1;
            tick();
            bus_a.out_ready = 1'b0;
        end
        total++; if (lvl_a !== 3'd0) begin bad++; $display("FAIL fp_empty got=%0d want=0", lvl_a); end
    endtask

    task automatic test_stall();
        bus_a.out_ready = 1'b1;
        toggle_a(10'h123, 10'h321);
        tick(); tick();
        tick();  // idle counter restarts from 0 at this edge
        repeat (399) tick();
        total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL stall_early got=%0h want=0", stall_a); end
        tick();
        total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL stall_set got=%0h want=1", stall_a); end
        repeat (50) tick();
        total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0h want=1", stall_a); end
        toggle_a(10'h0AA, 10'h055);
        tick(); tick();  // detect cycle
        total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL stall_in_detect got=%0h want=1", stall_a); end
        tick();
        total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL stall_release got=%0h want=0", stall_a); end
        exp_cnt = exp_cnt + 16'd2;
        tick();
        total++; if (cnt_a !== exp_cnt) begin bad++; $display("FAIL stall_count got=%0d want=%0d", cnt_a, exp_cnt); end
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_reset_flush();
        toggle_a(10'h0AB, 10'h0CD);
        repeat (4) tick();
        total++; if (lvl_a !== 3'd1) begin bad++; $display("FAIL flush_pre got=%0d want=1", lvl_a); end
        reset = 1'b1;
        ev_a = 1'b1;
        repeat (6) tick();
        reset = 1'b0;
        repeat (20) tick();
        total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", bus_a.out_valid); end
        total++; if (lvl_a !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", lvl_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", cnt_a); end
        toggle_a(10'h3E8, 10'h017);  // 1 -> 0
        repeat (4) tick();
        total++; if (lvl_a !== 3'd1) begin bad++; $display("FAIL post_level got=%0d want=1", lvl_a); end
        total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL post_count got=%0d want=1", cnt_a); end
        total++; if (bus_a.out_i !== 10'h1E8) begin bad++; $display("FAIL post_i got=%0h want=1e8", bus_a.out_i); end
        total++; if (bus_a.out_q !== 10'h217) begin bad++; $display("FAIL post_q got=%0h want=217", bus_a.out_q); end
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    task automatic test_count_wrap();
        logic [9:0] vi;
        logic [9:0] vq;
        bus_b.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            vi = 10'(k * 65 + 3);
            vq = ~vi;
            i_b = vi;
            q_b = vq;
            tick();
            ev_b = ~ev_b;
            tick(); tick(); tick();  // push edge
            total++; if (bus_b.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid%0d got=%0h want=1", k, bus_b.out_valid); end
            total++; if (bus_b.out_i !== vi) begin bad++; $display("FAIL wrap_i%0d got=%0h want=%0h", k, bus_b.out_i, vi); end
            total++; if (bus_b.out_q !== vq) begin bad++; $display("FAIL wrap_q%0d got=%0h want=%0h", k, bus_b.out_q, vq); end
            tick(); tick();
        end
        total++; if (cnt_b !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", cnt_b); end
        total++; if (bus_b.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%0h want=0", bus_b.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_stall();
        test_reset_flush();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_sample_capture.md
Name: iq_sample_capture

Overview:
- Consumer end of the ADC sample-toggle interface. The sample source presents 10-bit I and Q words and flips sample_event once per new sample, asynchronous to clk (nominal 1 MHz samples, 200 MHz clk).
- The block synchronizes the toggle, detects each flip and latches I/Q. It converts offset-binary to two's complement and buffers samples in a small FIFO with a valid/ready output to downstream DSP.
- It also reports overflow, source-stall and a sample count.

Parameters:
- DATA_W, 10, width of I and Q words.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, minimum 2.
- OFFSET_BINARY, 1, 1 = invert MSB on capture (offset-binary to two's complement); 0 = pass through unchanged.
- TIMEOUT_CYCLES, 400, clk cycles without a detected toggle before stall asserts.
- COUNT_W, 16, width of sample_count.

Ports:
- clk  in  1  main clock.
- reset  in  1  synchronous, active-high reset.
- i_in  in  DATA_W  I word from source; quasi-static around toggles.
- q_in  in  DATA_W  Q word from source; quasi-static around toggles.
- sample_event  in  1  toggles once per new sample; asynchronous to clk.
- out_ready  in  1  downstream accepts the head sample.
- out_valid  out  1  FIFO non-empty.
- out_i  out  DATA_W  head-of-FIFO I.
- out_q  out  DATA_W  head-of-FIFO Q.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- stall  out  1  no sample detected for TIMEOUT_CYCLES.
- clr_flags  in  1  single-cycle pulse; clears overflow.
- sample_count  out  COUNT_W  samples written into the FIFO; wraps modulo 2^COUNT_W.

Behaviour:
- Synchronizer:
  - Three flops s1 <= sample_event, s2 <= s1, s3 <= s2. detect = s2 ^ s3.
  - The chain is NOT cleared by reset; it keeps tracking so no spurious edge appears at reset release.
  - detect is ignored while reset = 1.
- Latency: a toggle meeting setup before clk edge k gives detect = 1 during cycle k+2. I/Q are sampled at the edge closing cycle k+2.
- Source timing contract: i_in/q_in are stable from before the toggle until at least 4 clk after it. i_in/q_in are not synchronized.
- Conversion:
  - OFFSET_BINARY = 1: stored = {~in[DATA_W-1], in[DATA_W-2:0]}. Example: 10'h200 -> 10'h000; 10'h000 -> 10'h200.
  - OFFSET_BINARY = 0: stored = in.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an explicit level.
  - out_i/out_q/out_valid are driven directly from the head entry and level (no extra register stage).
  - A sample written at edge E is visible on out_valid after E when the FIFO was empty.
  - Pop when out_valid & out_ready.
  - Push when detect & (level < FIFO_DEPTH, or a pop occurs in the same cycle). Simultaneous push and pop on a full FIFO succeeds: level is unchanged, no overflow.
  - Level updates: push only +1; pop only -1; both 0 net.
  - out_ready with an empty FIFO has no effect.
- Overflow: detect while full with no pop -> sample dropped, overflow set, sample_count not incremented. clr_flags clears overflow. If an overflow event and clr_flags coincide, overflow stays set.
- sample_count: increments on every successful push; wraps from all-ones to 0.
- Stall watchdog:
  - Counter reset to 0 on reset and on every detect; otherwise increments, saturating at TIMEOUT_CYCLES.
  - stall = (counter == TIMEOUT_CYCLES). It deasserts the cycle after the next detect.
- Reset values: out_valid 0, fifo_level 0, overflow 0, stall 0, sample_count 0; FIFO pointers 0. out_i/out_q contents are don't-care while out_valid = 0.
- Reset mid-operation flushes the FIFO and clears flags and counters. A toggle occurring during reset is lost. Toggles after release are detected normally.

Test Plan:
- Basic capture: toggle with i_in = 10'h3FF, q_in = 10'h000, out_ready = 1. Required: out_valid high for 1 cycle, 3 edges after the toggle-sampling edge; out_i = 10'h1FF, out_q = 10'h200; sample_count = 1.
- Backpressure/overflow: out_ready = 0, 6 toggles spaced 200 cycles apart, DEPTH 4. Required: level 4; overflow = 1 after the 5th toggle; sample_count = 4. Draining yields samples 1-4 in order. clr_flags clears overflow.
- Full + simultaneous pop: FIFO full, out_ready = 1 in the detect cycle. Required: level stays 4, overflow stays 0, sample_count increments.
- Stall: no toggles for 400 cycles. Required: stall = 1 at cycle 400 and held. A toggle then deasserts stall 1 cycle after detect.
- Reset with sample_event = 1: hold reset with sample_event = 1, then release. Required: no sample pushed; the next toggle (1 -> 0) is captured normally.
- Count wrap: COUNT_W = 4, 17 toggles with out_ready = 1. Required: sample_count = 1. OFFSET_BINARY = 0 run: output equals input bit-exact.
